// File: rtl/ex_muldiv_if.sv
// Operand, control and HI/LO result bundle between EX-stage decode and the multiply/divide unit.
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one radix-2 step per cycle.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise only MULT/MULTU are accepted.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_negRes;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;

  logic               w_signed;
  logic               w_signA;
  logic               w_signB;
  logic               w_accept;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_stepAcc;
  logic [2*WIDTH-1:0] w_prod;

`ifdef MULDIV_DIV_EN
  logic               r_isDiv;
  logic               r_negRem;
  logic               r_divZero;
  logic               w_bZero;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
`endif

  assign w_signed = ~bus.op[0];
  assign w_signA  = w_signed & bus.a[WIDTH-1];
  assign w_signB  = w_signed & bus.b[WIDTH-1];
  assign w_absA   = w_signA ? -bus.a : bus.a;
  assign w_absB   = w_signB ? -bus.b : bus.b;

`ifdef MULDIV_DIV_EN
  assign w_bZero  = (bus.b == '0);
  assign w_accept = (r_state == IDLE) & bus.start & ~bus.flush;
`else
  assign w_accept = (r_state == IDLE) & bus.start & ~bus.flush & ~bus.op[1];
`endif

  // The last of the WIDTH steps is evaluated here and consumed directly by the FIXUP write.
  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_stepAcc = {w_sum, r_acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    w_trial   = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
    if (r_isDiv) begin
      w_stepAcc = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                 : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
`endif
    w_prod = r_negRes ? -w_stepAcc : w_stepAcc;
  end

`ifdef MULDIV_DIV_EN
  assign w_quot = r_negRes ? -w_stepAcc[WIDTH-1:0] : w_stepAcc[WIDTH-1:0];
  assign w_rem  = r_negRem ? -w_stepAcc[2*WIDTH-1:WIDTH] : w_stepAcc[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_negRes  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_isDiv   <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.hi_we) r_hi <= bus.wdata;
          if (bus.lo_we) r_lo <= bus.wdata;
          if (w_accept) begin
            r_state  <= RUN;
            r_busy   <= 1'b1;
            r_count  <= CW'(WIDTH);
            r_acc    <= {{WIDTH{1'b0}}, w_absB};
            r_opnd   <= w_absA;
            r_negRes <= w_signA ^ w_signB;
`ifdef MULDIV_DIV_EN
            r_isDiv   <= bus.op[1];
            r_divZero <= w_bZero;
            r_negRem  <= 1'b0;
            // Divide by zero runs on the raw dividend with no sign fixup so HI ends as the original a.
            if (bus.op[1]) begin
              r_acc    <= {{WIDTH{1'b0}}, (w_bZero ? bus.a : w_absA)};
              r_opnd   <= w_absB;
              r_negRes <= ~w_bZero & (w_signA ^ w_signB);
              r_negRem <= ~w_bZero & w_signA;
            end
`endif
          end
        end
        RUN: begin
          if (bus.flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc   <= w_stepAcc;
            r_count <= r_count - CW'(1);
            if (r_count == CW'(2)) r_state <= FIXUP;
          end
        end
        FIXUP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (!bus.flush) begin
            r_done       <= 1'b1;
            {r_hi, r_lo} <= w_prod;
`ifdef MULDIV_DIV_EN
            if (r_isDiv) begin
              r_hi  <= w_rem;
              r_lo  <= w_quot;
              r_dbz <= r_divZero;
            end
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: reset, MULT/MULTU, DIV/DIVU when MULDIV_DIV_EN is defined, MTHI/MTLO, flush.
module tb_ex_muldiv;
  localparam int WIDTH = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clock = 1'b0;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;
  logic [1:0] flushOp;
  logic sawDone;

  ex_muldiv_if #(.WIDTH(WIDTH)) bus ();

  ex_muldiv #(.WIDTH(WIDTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs are driven just after a falling edge and held across exactly one rising edge.
  task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [WIDTH-1:0] av,
                               input logic [WIDTH-1:0] bv, input logic fl, input logic hwe,
                               input logic lwe, input logic [WIDTH-1:0] wd);
    bus.start = s;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    bus.flush = fl;
    bus.hi_we = hwe;
    bus.lo_we = lwe;
    bus.wdata = wd;
    @(negedge clock);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, OP_MULT, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic runOp(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] expHi,
                       input logic [WIDTH-1:0] expLo, input logic expDbz);
    int cycles = 0;
    applyStimulus(1'b1, o, av, bv, 1'b0, 1'b0, 1'b0, '0);
    while (bus.busy === 1'b1 && cycles < 100) begin
      cycles++;
      idleCycle();
    end
    checkOutput({tag, " busy cycles"}, 64'(cycles), 64'(WIDTH));
    checkOutput({tag, " done"}, 64'(bus.done), 64'd1);
    checkOutput({tag, " hi"}, 64'(bus.hi), 64'(expHi));
    checkOutput({tag, " lo"}, 64'(bus.lo), 64'(expLo));
    checkOutput({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(expDbz));
  endtask

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (2) @(negedge clock);
    checkOutput("reset hi", 64'(bus.hi), 64'd0);
    checkOutput("reset lo", 64'(bus.lo), 64'd0);
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset done", 64'(bus.done), 64'd0);
    checkOutput("reset div_by_zero", 64'(bus.div_by_zero), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    runOp("MULTU max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    idleCycle();
    checkOutput("MULTU max done single pulse", 64'(bus.done), 64'd0);
    runOp("MULT -3*7", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);

    $display("[TB] reset in the middle of a MULT");
    applyStimulus(1'b1, OP_MULT, 32'd3, 32'd7, 1'b0, 1'b0, 1'b0, '0);
    repeat (4) idleCycle();
    checkOutput("midop busy before reset", 64'(bus.busy), 64'd1);
    #3 reset = 1'b0;
    #1;
    checkOutput("midop reset hi", 64'(bus.hi), 64'd0);
    checkOutput("midop reset lo", 64'(bus.lo), 64'd0);
    checkOutput("midop reset busy", 64'(bus.busy), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    applyStimulus(1'b0, OP_MULT, '0, '0, 1'b0, 1'b0, 1'b1, 32'h5);
    checkOutput("MTLO after reset lo", 64'(bus.lo), 64'h5);
    checkOutput("MTLO after reset hi", 64'(bus.hi), 64'h0);

    runOp("MULT -5*-6", OP_MULT, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0, 32'h1E, 1'b0);
    runOp("MULTU shift", OP_MULTU, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0);
    runOp("MULT min*min", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
    runOp("MULT min*1", OP_MULT, 32'h80000000, 32'h1, 32'hFFFFFFFF, 32'h80000000, 1'b0);

`ifdef MULDIV_DIV_EN
    runOp("DIV -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    runOp("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0);
    runOp("DIV overflow", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    runOp("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    runOp("DIVU 100/0", OP_DIVU, 32'd100, 32'd0, 32'h64, 32'hFFFFFFFF, 1'b1);
    idleCycle();
    checkOutput("DIVU by zero flag single pulse", 64'(bus.div_by_zero), 64'd0);
    runOp("DIV -100/0", OP_DIV, 32'hFFFFFF9C, 32'd0, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1);
    flushOp = OP_DIVU;
`else
    applyStimulus(1'b1, OP_DIV, 32'd9, 32'd3, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("DIV ignored busy", 64'(bus.busy), 64'd0);
    applyStimulus(1'b1, OP_DIVU, 32'd9, 32'd0, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("DIVU ignored busy", 64'(bus.busy), 64'd0);
    checkOutput("DIVU ignored lo", 64'(bus.lo), 64'h80000000);
    flushOp = OP_MULTU;
`endif

    $display("[TB] flush of an in-flight operation");
    applyStimulus(1'b0, OP_MULT, '0, '0, 1'b0, 1'b1, 1'b0, 32'h11);
    applyStimulus(1'b0, OP_MULT, '0, '0, 1'b0, 1'b0, 1'b1, 32'h22);
    checkOutput("preload hi", 64'(bus.hi), 64'h11);
    checkOutput("preload lo", 64'(bus.lo), 64'h22);
    applyStimulus(1'b1, flushOp, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0, '0);
    repeat (8) idleCycle();
    applyStimulus(1'b0, flushOp, 32'd1000, 32'd3, 1'b0, 1'b1, 1'b1, 32'h99);
    checkOutput("busy before flush", 64'(bus.busy), 64'd1);
    applyStimulus(1'b0, flushOp, 32'd1000, 32'd3, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("flush busy", 64'(bus.busy), 64'd0);
    checkOutput("flush hi kept", 64'(bus.hi), 64'h11);
    checkOutput("flush lo kept", 64'(bus.lo), 64'h22);
    sawDone = 1'b0;
    repeat (30) begin
      sawDone = sawDone | bus.done;
      idleCycle();
    end
    checkOutput("flush no done", 64'(sawDone), 64'd0);
    checkOutput("flush hi after wait", 64'(bus.hi), 64'h11);

    applyStimulus(1'b1, OP_MULTU, 32'd5, 32'd5, 1'b1, 1'b0, 1'b1, 32'h33);
    checkOutput("idle flush suppresses start", 64'(bus.busy), 64'd0);
    checkOutput("idle flush keeps MTLO", 64'(bus.lo), 64'h33);

    runOp("b2b first", OP_MULTU, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0);
    runOp("b2b second", OP_MULTU, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
